vend_txn_controller: RTL and testbench

Transaction sequencer in front of the smart_vending_machine dispensing datapath. It accumulates coin credit, checks price and per-product stock, and issues one purchase command at a time via a req/ack handshake. It then returns change or retains credit for a follow-on purchase (buy_more). Cancel, inactivity timeout and IDLE-only restocking are also handled here.

---
 rtl/vend_pkg.sv | 29 ++
 rtl/vend_inventory.sv | 49 ++++
 rtl/vend_txn_controller.sv | 231 +++++++++++++++++++++++
 tb/tb_vend_txn_controller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and default constants for the vending transaction controller.
package vend_pkg;

  localparam int unsigned CreditW     = 8;
  localparam int unsigned StockW      = 4;
  localparam int unsigned NumProducts = 4;

  typedef enum logic [1:0] {
    StIdle,
    StCredit,
    StVend
  } vend_state_e;

  // Product codes
  localparam logic [1:0] Prod0 = 2'b00;
  localparam logic [1:0] Prod1 = 2'b01;
  localparam logic [1:0] Prod2 = 2'b10;
  localparam logic [1:0] Prod3 = 2'b11;

  // Default prices (rupees) and limits
  localparam logic [CreditW-1:0] DefPrice0        = 8'd25;
  localparam logic [CreditW-1:0] DefPrice1        = 8'd50;
  localparam logic [CreditW-1:0] DefPrice2        = 8'd75;
  localparam logic [CreditW-1:0] DefPrice3        = 8'd100;
  localparam logic [CreditW-1:0] DefMaxCredit     = 8'd200;
  localparam logic [StockW-1:0]  DefInitStock     = 4'd5;
  localparam int unsigned        DefTimeoutCycles = 1000;

endpackage

// File: rtl/vend_inventory.sv
// Per-product stock counters with a restock load port, a vend decrement port
// and a combinational read mux for the currently selected product.
module vend_inventory
  import vend_pkg::*;
#(
  parameter logic [StockW-1:0] INIT_STOCK = DefInitStock
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [1:0]        load_id_i,
  input  logic [StockW-1:0] load_count_i,
  input  logic              dec_i,
  input  logic [1:0]        dec_id_i,
  input  logic [1:0]        rd_id_i,
  output logic [StockW-1:0] rd_count_o
);

  logic [NumProducts-1:0][StockW-1:0] stock_q, stock_d;

  // Next stock: load and decrement never coincide (IDLE vs VEND), load wins anyway.
  always_comb begin
    stock_d = stock_q;
    for (int i = 0; i < NumProducts; i++) begin
      if (load_i && (load_id_i == 2'(i))) begin
        stock_d[i] = load_count_i;
      end else if (dec_i && (dec_id_i == 2'(i)) && (stock_q[i] != '0)) begin
        stock_d[i] = stock_q[i] - 1'b1;
      end
    end
  end

  // Stock registers, restored to the initial fill on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumProducts; i++) begin
        stock_q[i] <= INIT_STOCK;
      end
    end else begin
      stock_q <= stock_d;
    end
  end

  // Read mux for the product being selected.
  always_comb begin
    rd_count_o = stock_q[rd_id_i];
  end

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: accumulates credit, validates selections
// against price and stock, issues one req/ack purchase at a time and returns
// change or keeps leftover credit for a follow-on purchase.
module vend_txn_controller
  import vend_pkg::*;
#(
  parameter logic [7:0]  PRICE_0        = DefPrice0,
  parameter logic [7:0]  PRICE_1        = DefPrice1,
  parameter logic [7:0]  PRICE_2        = DefPrice2,
  parameter logic [7:0]  PRICE_3        = DefPrice3,
  parameter logic [7:0]  MAX_CREDIT     = DefMaxCredit,
  parameter logic [3:0]  INIT_STOCK     = DefInitStock,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [7:0] coin_value,
  output logic       coin_reject,
  input  logic       sel_valid,
  input  logic [1:0] sel_product,
  input  logic       buy_more,
  input  logic       cancel,
  output logic       vend_req,
  output logic [1:0] vend_product,
  input  logic       vend_ack,
  output logic [7:0] credit,
  output logic [7:0] change,
  output logic       change_valid,
  output logic       insufficient,
  output logic       sold_out,
  input  logic       stock_load,
  input  logic [1:0] stock_id,
  input  logic [3:0] stock_count,
  output logic       busy
);

  localparam int unsigned     TimerW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);

  vend_state_e       state_q, state_d;
  logic [7:0]        credit_q, credit_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              buy_more_q, buy_more_d;
  logic              vend_req_q, vend_req_d;
  logic [1:0]        vend_product_q, vend_product_d;
  logic              coin_reject_q, coin_reject_d;
  logic [7:0]        change_q, change_d;
  logic              change_valid_q, change_valid_d;
  logic              insufficient_q, insufficient_d;
  logic              sold_out_q, sold_out_d;
  logic              busy_q, busy_d;

  logic              coin_ok;
  logic [8:0]        coin_sum;
  logic [7:0]        price_sel;
  logic [3:0]        stock_sel;
  logic              inv_load;
  logic              inv_dec;

  // A zero-valued coin strobe is treated as no coin at all.
  assign coin_ok  = coin_valid && (coin_value != 8'd0);
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};

  // Price lookup for the product being selected.
  always_comb begin
    price_sel = PRICE_0;
    unique case (sel_product)
      Prod0: price_sel = PRICE_0;
      Prod1: price_sel = PRICE_1;
      Prod2: price_sel = PRICE_2;
      Prod3: price_sel = PRICE_3;
      default: price_sel = PRICE_0;
    endcase
  end

  vend_inventory #(
    .INIT_STOCK(INIT_STOCK)
  ) u_inventory (
    .clk_i       (clk),
    .rst_i       (reset),
    .load_i      (inv_load),
    .load_id_i   (stock_id),
    .load_count_i(stock_count),
    .dec_i       (inv_dec),
    .dec_id_i    (vend_product_q),
    .rd_id_i     (sel_product),
    .rd_count_o  (stock_sel)
  );

  // Transaction next-state and registered-output computation.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    timer_d        = timer_q;
    buy_more_d     = buy_more_q;
    vend_req_d     = vend_req_q;
    vend_product_d = vend_product_q;
    coin_reject_d  = 1'b0;
    change_d       = 8'd0;
    change_valid_d = 1'b0;
    insufficient_d = 1'b0;
    sold_out_d     = 1'b0;
    inv_load       = 1'b0;
    inv_dec        = 1'b0;

    unique case (state_q)
      StIdle: begin
        inv_load = stock_load;
        if (coin_ok) begin
          if (coin_value > MAX_CREDIT) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_value;
            timer_d  = '0;
            state_d  = StCredit;
          end
        end
        if (sel_valid) begin
          insufficient_d = 1'b1;
        end
      end

      StCredit: begin
        if (cancel) begin
          coin_reject_d  = coin_ok;
          change_d       = credit_q;
          change_valid_d = 1'b1;
          credit_d       = 8'd0;
          timer_d        = '0;
          state_d        = StIdle;
        end else if (sel_valid) begin
          coin_reject_d = coin_ok;
          timer_d       = '0;
          if (stock_sel == 4'd0) begin
            sold_out_d = 1'b1;
          end else if (credit_q < price_sel) begin
            insufficient_d = 1'b1;
          end else begin
            credit_d       = credit_q - price_sel;
            buy_more_d     = buy_more;
            vend_product_d = sel_product;
            vend_req_d     = 1'b1;
            state_d        = StVend;
          end
        end else if (coin_ok) begin
          timer_d = '0;
          if (coin_sum > {1'b0, MAX_CREDIT}) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_sum[7:0];
          end
        end else if (timer_q == TimeoutLast) begin
          // Inactivity timeout behaves exactly like cancel.
          change_d       = credit_q;
          change_valid_d = 1'b1;
          credit_d       = 8'd0;
          timer_d        = '0;
          state_d        = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StVend: begin
        coin_reject_d = coin_ok;
        if (vend_ack) begin
          vend_req_d = 1'b0;
          inv_dec    = 1'b1;
          if (buy_more_q && (credit_q != 8'd0)) begin
            timer_d = '0;
            state_d = StCredit;
          end else begin
            change_d       = credit_q;
            change_valid_d = 1'b1;
            credit_d       = 8'd0;
            state_d        = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StVend);
  end

  // State and registered outputs; reset abandons any vend without refund.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      credit_q       <= 8'd0;
      timer_q        <= '0;
      buy_more_q     <= 1'b0;
      vend_req_q     <= 1'b0;
      vend_product_q <= 2'd0;
      coin_reject_q  <= 1'b0;
      change_q       <= 8'd0;
      change_valid_q <= 1'b0;
      insufficient_q <= 1'b0;
      sold_out_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      timer_q        <= timer_d;
      buy_more_q     <= buy_more_d;
      vend_req_q     <= vend_req_d;
      vend_product_q <= vend_product_d;
      coin_reject_q  <= coin_reject_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      insufficient_q <= insufficient_d;
      sold_out_q     <= sold_out_d;
      busy_q         <= busy_d;
    end
  end

  assign coin_reject  = coin_reject_q;
  assign vend_req     = vend_req_q;
  assign vend_product = vend_product_q;
  assign credit       = credit_q;
  assign change       = change_q;
  assign change_valid = change_valid_q;
  assign insufficient = insufficient_q;
  assign sold_out     = sold_out_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vend_txn_controller.sv
// Directed bench for vend_txn_controller: linear sequence of transactions with
// hand-computed expected outputs checked by immediate assertions.
module tb_vend_txn_controller;
  import vend_pkg::*;

  logic       clk;
  logic       reset;
  logic       coin_valid;
  logic [7:0] coin_value;
  logic       coin_reject;
  logic       sel_valid;
  logic [1:0] sel_product;
  logic       buy_more;
  logic       cancel;
  logic       vend_req;
  logic [1:0] vend_product;
  logic       vend_ack;
  logic [7:0] credit;
  logic [7:0] change;
  logic       change_valid;
  logic       insufficient;
  logic       sold_out;
  logic       stock_load;
  logic [1:0] stock_id;
  logic [3:0] stock_count;
  logic       busy;

  int n_tests;
  int n_fail;

  vend_txn_controller dut (
    .clk         (clk),
    .reset       (reset),
    .coin_valid  (coin_valid),
    .coin_value  (coin_value),
    .coin_reject (coin_reject),
    .sel_valid   (sel_valid),
    .sel_product (sel_product),
    .buy_more    (buy_more),
    .cancel      (cancel),
    .vend_req    (vend_req),
    .vend_product(vend_product),
    .vend_ack    (vend_ack),
    .credit      (credit),
    .change      (change),
    .change_valid(change_valid),
    .insufficient(insufficient),
    .sold_out    (sold_out),
    .stock_load  (stock_load),
    .stock_id    (stock_id),
    .stock_count (stock_count),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_coin(input logic [7:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    tick();
    coin_valid = 1'b0;
    coin_value = 8'd0;
  endtask

  task automatic do_sel(input logic [1:0] p, input logic bm);
    sel_valid   = 1'b1;
    sel_product = p;
    buy_more    = bm;
    tick();
    sel_valid   = 1'b0;
    sel_product = 2'd0;
    buy_more    = 1'b0;
  endtask

  task automatic do_ack();
    vend_ack = 1'b1;
    tick();
    vend_ack = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    coin_valid  = 1'b0;
    coin_value  = 8'd0;
    sel_valid   = 1'b0;
    sel_product = 2'd0;
    buy_more    = 1'b0;
    cancel      = 1'b0;
    vend_ack    = 1'b0;
    stock_load  = 1'b0;
    stock_id    = 2'd0;
    stock_count = 4'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_vend_req", vend_req, 0);
    chk("rst_credit", credit, 0);
    chk("rst_change_valid", change_valid, 0);
    chk("rst_vend_product", vend_product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dut.state_q, StIdle);
    chk("rst_stock0", dut.u_inventory.stock_q[0], 5);

    // 1: exact-price purchase, ack two cycles after req
    do_coin(8'd25);
    chk("t1_credit", credit, 25);
    chk("t1_state_credit", dut.state_q, StCredit);
    do_sel(2'b00, 1'b0);
    chk("t1_req", vend_req, 1);
    chk("t1_busy", busy, 1);
    chk("t1_credit_after_sel", credit, 0);
    tick();
    chk("t1_req_held1", vend_req, 1);
    tick();
    chk("t1_req_held2", vend_req, 1);
    do_ack();
    chk("t1_req_drop", vend_req, 0);
    chk("t1_change_valid", change_valid, 1);
    chk("t1_change", change, 0);
    chk("t1_stock0", dut.u_inventory.stock_q[0], 4);
    chk("t1_state_idle", dut.state_q, StIdle);
    chk("t1_busy_low", busy, 0);
    tick();
    chk("t1_change_valid_pulse", change_valid, 0);

    // 2: insufficient credit then cancel
    do_coin(8'd25);
    do_sel(2'b01, 1'b0);
    chk("t2_insufficient", insufficient, 1);
    chk("t2_credit", credit, 25);
    chk("t2_no_req", vend_req, 0);
    tick();
    chk("t2_insufficient_pulse", insufficient, 0);
    do_cancel();
    chk("t2_change_valid", change_valid, 1);
    chk("t2_change", change, 25);
    chk("t2_credit_zero", credit, 0);

    // 3: change returned, then credit ceiling
    do_coin(8'd100);
    do_sel(2'b10, 1'b0);
    chk("t3_req", vend_req, 1);
    chk("t3_product", vend_product, 2);
    chk("t3_credit", credit, 25);
    do_ack();
    chk("t3_change_valid", change_valid, 1);
    chk("t3_change", change, 25);
    chk("t3_stock2", dut.u_inventory.stock_q[2], 4);
    do_coin(8'd100);
    do_coin(8'd100);
    chk("t3_credit200", credit, 200);
    chk("t3_no_reject", coin_reject, 0);
    do_coin(8'd10);
    chk("t3_reject", coin_reject, 1);
    chk("t3_credit_held", credit, 200);
    do_cancel();
    chk("t3_refund", change, 200);

    // 4: buy_more keeps leftover credit for a second purchase
    do_coin(8'd100);
    do_sel(2'b00, 1'b1);
    chk("t4_credit75", credit, 75);
    do_ack();
    chk("t4_no_change", change_valid, 0);
    chk("t4_state_credit", dut.state_q, StCredit);
    chk("t4_credit_kept", credit, 75);
    chk("t4_stock0", dut.u_inventory.stock_q[0], 3);
    do_sel(2'b01, 1'b0);
    chk("t4_req2", vend_req, 1);
    chk("t4_product2", vend_product, 1);
    chk("t4_credit25", credit, 25);
    do_coin(8'd5);
    chk("t4_vend_coin_reject", coin_reject, 1);
    chk("t4_vend_credit", credit, 25);
    do_ack();
    chk("t4_change_valid", change_valid, 1);
    chk("t4_change", change, 25);
    chk("t4_state_idle", dut.state_q, StIdle);

    // 5: restock, sold out, restock ignored outside IDLE, inactivity timeout
    stock_load  = 1'b1;
    stock_id    = 2'b11;
    stock_count = 4'd0;
    tick();
    stock_load  = 1'b0;
    chk("t5_stock3", dut.u_inventory.stock_q[3], 0);
    do_coin(8'd100);
    stock_load  = 1'b1;
    stock_id    = 2'b01;
    stock_count = 4'd9;
    tick();
    stock_load  = 1'b0;
    chk("t5_load_ignored", dut.u_inventory.stock_q[1], 4);
    do_sel(2'b11, 1'b0);
    chk("t5_sold_out", sold_out, 1);
    chk("t5_credit", credit, 100);
    chk("t5_no_req", vend_req, 0);
    for (int i = 0; i < 999; i++) begin
      tick();
    end
    chk("t5_before_timeout_cv", change_valid, 0);
    chk("t5_before_timeout_state", dut.state_q, StCredit);
    tick();
    chk("t5_timeout_cv", change_valid, 1);
    chk("t5_timeout_change", change, 100);
    chk("t5_timeout_state", dut.state_q, StIdle);
    chk("t5_timeout_credit", credit, 0);

    // 6: reset during VEND
    do_coin(8'd50);
    do_sel(2'b01, 1'b0);
    chk("t6_req", vend_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_req_drop", vend_req, 0);
    chk("t6_credit", credit, 0);
    chk("t6_no_change", change_valid, 0);
    chk("t6_state", dut.state_q, StIdle);
    chk("t6_stock0", dut.u_inventory.stock_q[0], 5);
    chk("t6_stock1", dut.u_inventory.stock_q[1], 5);
    chk("t6_stock2", dut.u_inventory.stock_q[2], 5);
    chk("t6_stock3", dut.u_inventory.stock_q[3], 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
